// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e  : fetch FSM states (request allowed / one request outstanding)
//   FetchBufHw     : alignment buffer depth in halfwords
//   is_compressed  : RVC detection from the two low opcode bits
package fetch_ctrl_pkg;

    localparam int unsigned DataWidthDefault   = 32;
    localparam int unsigned MemBusWidthDefault = 32;
    localparam logic [31:0] ResetVectorDefault = 32'h0000_0000;

    localparam int unsigned FetchBufHw = 4;
    localparam int unsigned HwWidth    = 16;
    localparam int unsigned CountWidth = 3;
    localparam int unsigned InstrWidth = 32;
    localparam int unsigned LenWidth   = 3;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

    // Any opcode whose low two bits are not 2'b11 is a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] op);
        return op != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_buf.sv
// Halfword alignment buffer for the fetch path.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : empty the buffer (wins over push and pop)
//   push_lo_en_i   : append push_data_i[15:0]
//   push_hi_en_i   : append push_data_i[31:16] (after the low half if both)
//   push_data_i    : returned memory word, little-endian halfwords
//   pop_cnt_i      : halfwords removed from the head this cycle (0..2)
//   hw0_o, hw1_o   : the two oldest halfwords
//   count_o        : occupancy in halfwords (0..4)
module fetch_align_buf
    import fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_lo_en_i,
    input  logic                  push_hi_en_i,
    input  logic [2*HwWidth-1:0]  push_data_i,
    input  logic [1:0]            pop_cnt_i,
    output logic [HwWidth-1:0]    hw0_o,
    output logic [HwWidth-1:0]    hw1_o,
    output logic [CountWidth-1:0] count_o
);

    localparam int unsigned BufWidth = FetchBufHw * HwWidth;

    logic [BufWidth-1:0]   buf_q;
    logic [BufWidth-1:0]   buf_d;
    logic [BufWidth-1:0]   shifted;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_d;
    logic [CountWidth-1:0] base;
    logic [CountWidth-1:0] hi_idx;

    // Head halfword sits in the low bits; popping shifts the rest down.
    assign shifted = buf_q >> (HwWidth * 32'(pop_cnt_i));

    // Pushes land after whatever survives this cycle's pop.
    assign base   = count_q - CountWidth'(pop_cnt_i);
    assign hi_idx = base + CountWidth'(push_lo_en_i);

    // Storage next state.
    always_comb begin
        buf_d = shifted;
        for (int unsigned i = 0; i < FetchBufHw; i++) begin
            if (push_lo_en_i && (base == CountWidth'(i))) begin
                buf_d[i*HwWidth +: HwWidth] = push_data_i[HwWidth-1:0];
            end
            if (push_hi_en_i && (hi_idx == CountWidth'(i))) begin
                buf_d[i*HwWidth +: HwWidth] = push_data_i[2*HwWidth-1:HwWidth];
            end
        end
    end

    // Occupancy next state; stale contents after a flush are masked by count.
    always_comb begin
        count_d = hi_idx + CountWidth'(push_hi_en_i);
        if (flush_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign hw0_o   = buf_q[HwWidth-1:0];
    assign hw1_o   = buf_q[2*HwWidth-1:HwWidth];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues word requests with a
// req/gnt/rvalid handshake, and aligns returned words into 16/32-bit
// instructions through fetch_align_buf.
//   clk, rst_n              : clock, asynchronous active-low reset
//   mem_req, mem_addr       : fetch request and word-aligned address
//   mem_gnt                 : request accepted this cycle
//   mem_rvalid, mem_rdata   : in-order read response, one per grant
//   redirect, redirect_pc   : flush and restart at redirect_pc (bit 0 ignored)
//   instr_valid/instr_ready : instruction handshake towards the pipeline
//   instr, instr_pc         : instruction (RVC zero-extended) and its PC
//   instr_len               : PC increment, 2 or 4
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned          DataWidth   = DataWidthDefault,
    parameter int unsigned          MemBusWidth = MemBusWidthDefault,
    parameter logic [DataWidth-1:0] ResetVector = DataWidth'(ResetVectorDefault)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [DataWidth-1:0]   mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [MemBusWidth-1:0] mem_rdata,
    input  logic                   redirect,
    input  logic [DataWidth-1:0]   redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [InstrWidth-1:0]  instr,
    output logic [DataWidth-1:0]   instr_pc,
    output logic [LenWidth-1:0]    instr_len
);

    localparam logic [DataWidth-1:0] HwMask   = ~DataWidth'(1);
    localparam logic [DataWidth-1:0] WordMask = ~DataWidth'(3);

    fetch_state_e          state_q, state_d;
    logic [DataWidth-1:0]  fetch_addr_q, fetch_addr_d;
    logic [DataWidth-1:0]  instr_pc_q, instr_pc_d;
    logic                  discard_q, discard_d;
    logic                  skip_lo_q, skip_lo_d;

    logic                  buf_flush;
    logic                  push_lo_en;
    logic                  push_hi_en;
    logic [1:0]            pop_cnt;
    logic [HwWidth-1:0]    hw0;
    logic [HwWidth-1:0]    hw1;
    logic [CountWidth-1:0] buf_count;

    logic                  head_rvc;
    logic                  rsp;
    logic                  fire;

    fetch_align_buf u_align_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (buf_flush),
        .push_lo_en_i (push_lo_en),
        .push_hi_en_i (push_hi_en),
        .push_data_i  (mem_rdata),
        .pop_cnt_i    (pop_cnt),
        .hw0_o        (hw0),
        .hw1_o        (hw1),
        .count_o      (buf_count)
    );

    // Decode at the buffer head; a 32-bit instruction waits for its second half.
    assign head_rvc = is_compressed(hw0[1:0]);

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_len   = LenWidth'(4);
        if (head_rvc && (buf_count >= CountWidth'(1))) begin
            instr_valid = 1'b1;
            instr       = {16'h0000, hw0};
            instr_len   = LenWidth'(2);
        end else if (!head_rvc && (buf_count >= CountWidth'(2))) begin
            instr_valid = 1'b1;
            instr       = {hw1, hw0};
            instr_len   = LenWidth'(4);
        end
    end

    assign instr_pc = instr_pc_q;
    assign mem_addr = fetch_addr_q;
    assign fire     = instr_valid && instr_ready;
    assign rsp      = mem_rvalid && (state_q == FETCH_WAIT);

    // Request only when a full word still fits; held off while reset is applied.
    assign mem_req = rst_n && (state_q == FETCH_RUN) && !redirect
                     && (buf_count <= CountWidth'(FetchBufHw - 2));

    // Next-state logic; redirect overrides push, pop and request.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        instr_pc_d   = instr_pc_q;
        discard_d    = discard_q;
        skip_lo_d    = skip_lo_q;
        buf_flush    = 1'b0;
        push_lo_en   = 1'b0;
        push_hi_en   = 1'b0;
        pop_cnt      = 2'd0;

        if (redirect) begin
            buf_flush    = 1'b1;
            instr_pc_d   = redirect_pc & HwMask;
            fetch_addr_d = redirect_pc & WordMask;
            skip_lo_d    = redirect_pc[1];
            // The response still in flight belongs to the old stream.
            if ((state_q == FETCH_WAIT) && !mem_rvalid) begin
                discard_d = 1'b1;
                state_d   = FETCH_WAIT;
            end else begin
                discard_d = 1'b0;
                state_d   = FETCH_RUN;
            end
        end else begin
            if (rsp) begin
                state_d = FETCH_RUN;
                if (discard_q) begin
                    discard_d = 1'b0;
                end else begin
                    // A redirect to an odd halfword drops the word's low half once.
                    push_lo_en = !skip_lo_q;
                    push_hi_en = 1'b1;
                    skip_lo_d  = 1'b0;
                end
            end
            if (mem_req && mem_gnt) begin
                state_d      = FETCH_WAIT;
                fetch_addr_d = fetch_addr_q + DataWidth'(4);
            end
            if (fire) begin
                pop_cnt    = (instr_len == LenWidth'(2)) ? 2'd1 : 2'd2;
                instr_pc_d = instr_pc_q + DataWidth'(instr_len);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_RUN;
            fetch_addr_q <= ResetVector & WordMask;
            instr_pc_q   <= ResetVector;
            discard_q    <= 1'b0;
            skip_lo_q    <= ResetVector[1];
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            instr_pc_q   <= instr_pc_d;
            discard_q    <= discard_d;
            skip_lo_q    <= skip_lo_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// redirect/backpressure/reset sequences and a randomized run against an
// instruction-stream model derived from a memory image.
module tb_fetch_ctrl;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [DW-1:0] instr_pc;
    logic [2:0]    instr_len;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .DataWidth   (DW),
        .MemBusWidth (32),
        .ResetVector (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_len   (instr_len)
    );

    int checks   = 0;
    int failures = 0;

    // Memory image: a directed table or an address hash.
    bit          dir_mode;
    logic [31:0] dir_mem [256];

    // Model state.
    bit          pending;
    logic [31:0] pend_addr;
    int unsigned wait_cnt;
    int unsigned lat_min;
    int unsigned lat_max;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    bit          prev_stall;
    logic [31:0] stall_addr;
    bit          prev_hold;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    bit          prev_redir;
    int          cyc;
    int          first_valid_cyc;
    logic [31:0] acc_instr [$];
    logic [31:0] acc_pc    [$];
    logic [2:0]  acc_len   [$];
    logic [31:0] grant_q   [$];

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] i0;
        logic [31:0] p0;
        logic [2:0]  l0;
        logic [31:0] i1;
        logic [31:0] p1;
        logic [2:0]  l1;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (dir_mode) return dir_mem[a[9:2]];
        return (a * 32'h9E37_79B1) ^ (a >> 3) ^ 32'h5A5A_3C3C;
    endfunction

    function automatic logic [15:0] mem_hw(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic model_clear();
        pending         = 1'b0;
        pend_addr       = '0;
        wait_cnt        = 0;
        exp_pc          = '0;
        exp_fetch       = '0;
        prev_stall      = 1'b0;
        prev_hold       = 1'b0;
        prev_redir      = 1'b0;
        cyc             = 0;
        first_valid_cyc = -1;
        acc_instr.delete();
        acc_pc.delete();
        acc_len.delete();
        grant_q.delete();
    endtask

    task automatic idle_inputs();
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},     32'(mem_req), 0);
        check({tag, "_mem_addr"},    mem_addr, 32'h0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 0);
        check({tag, "_instr"},       instr, 32'h0);
        check({tag, "_instr_pc"},    instr_pc, 32'h0);
        check({tag, "_instr_len"},   32'(instr_len), 4);
    endtask

    task automatic do_reset(input bit check_vals);
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        @(posedge clk);
        #2;
        if (check_vals) check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic cycle(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          rv;
        logic [15:0] h0;
        logic [31:0] e_instr;
        logic [2:0]  e_len;
        rv          = pending && (wait_cnt == 0);
        mem_gnt     = gnt;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        mem_rvalid  = rv;
        mem_rdata   = rv ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        #1;
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (mem_req) check("fetch_addr", mem_addr, exp_fetch);
        if (pending) check("req_while_outstanding", 32'(mem_req), 0);
        if (redir) begin
            check("req_in_redirect", 32'(mem_req), 0);
        end else if (prev_stall) begin
            check("stall_req_held", 32'(mem_req), 1);
            check("stall_addr_held", mem_addr, stall_addr);
        end
        if (prev_redir) begin
            check("valid_after_redirect", 32'(instr_valid), 0);
        end else if (prev_hold) begin
            check("hold_valid", 32'(instr_valid), 1);
            check("hold_instr", instr, hold_instr);
            check("hold_pc", instr_pc, hold_pc);
        end
        if (instr_valid && rdy && !redir) begin
            h0 = mem_hw(exp_pc);
            if (h0[1:0] != 2'b11) begin
                e_instr = {16'h0000, h0};
                e_len   = 3'd2;
            end else begin
                e_instr = {mem_hw(exp_pc + 32'd2), h0};
                e_len   = 3'd4;
            end
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, e_instr);
            check("instr_len", 32'(instr_len), 32'(e_len));
            acc_instr.push_back(instr);
            acc_pc.push_back(instr_pc);
            acc_len.push_back(instr_len);
            exp_pc = exp_pc + 32'(e_len);
        end
        prev_hold  = instr_valid && !rdy && !redir;
        hold_instr = instr;
        hold_pc    = instr_pc;
        prev_redir = redir;
        prev_stall = mem_req && !gnt;
        stall_addr = mem_addr;
        if (redir) begin
            exp_pc    = rpc & ~32'h1;
            exp_fetch = rpc & ~32'h3;
        end
        if (rv) pending = 1'b0;
        else if (pending) wait_cnt--;
        if (mem_req && gnt) begin
            pending   = 1'b1;
            pend_addr = mem_addr;
            wait_cnt  = $urandom_range(lat_max, lat_min);
            exp_fetch = mem_addr + 32'd4;
            grant_q.push_back(mem_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill_dir(input logic [31:0] seed);
        for (int i = 0; i < 256; i++) begin
            dir_mem[i] = {16'(seed + 32'(i*8) + 5), 16'(seed + 32'(i*8) + 1)};
        end
    endtask

    initial begin
        int n0;
        logic [31:0] r;
        logic [31:0] rpc;

        rst_n    = 1'b0;
        dir_mode = 1'b1;
        lat_min  = 0;
        lat_max  = 0;
        fill_dir(32'h0);
        do_reset(1'b1);

        // Two-word programs, full-speed memory and consumer.
        vecs[0] = '{32'h0000_0413, 32'h0000_0001, 32'h0000_0413, 32'h0, 3'd4, 32'h0000_0001, 32'h4, 3'd2};
        vecs[1] = '{32'h4501_4081, 32'h0000_0001, 32'h0000_4081, 32'h0, 3'd2, 32'h0000_4501, 32'h2, 3'd2};
        vecs[2] = '{32'h0413_4081, 32'h1234_0000, 32'h0000_4081, 32'h0, 3'd2, 32'h0000_0413, 32'h2, 3'd4};
        vecs[3] = '{32'h00A0_0093, 32'h0011_8193, 32'h00A0_0093, 32'h0, 3'd4, 32'h0011_8193, 32'h4, 3'd4};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0, 3'd4, 32'h0000_0002, 32'h4, 3'd2};

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 256; i++) dir_mem[i] = 32'h0001_0001;
            dir_mem[0] = vecs[v].w0;
            dir_mem[1] = vecs[v].w1;
            do_reset(1'b0);
            for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
            check("vec_first_valid_cycle", 32'(first_valid_cyc), 32'd2);
            check("vec_accept_count", 32'(acc_instr.size() >= 2), 32'd1);
            if (acc_instr.size() >= 2) begin
                check("vec_i0", acc_instr[0], vecs[v].i0);
                check("vec_p0", acc_pc[0], vecs[v].p0);
                check("vec_l0", 32'(acc_len[0]), 32'(vecs[v].l0));
                check("vec_i1", acc_instr[1], vecs[v].i1);
                check("vec_p1", acc_pc[1], vecs[v].p1);
                check("vec_l1", 32'(acc_len[1]), 32'(vecs[v].l1));
            end
        end

        // Backpressure: consumer stalls, buffer fills, requests stop.
        fill_dir(32'h0);
        do_reset(1'b0);
        for (int c = 0; c < 12; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("bp_req_dropped", 32'(mem_req), 0);
        check("bp_valid", 32'(instr_valid), 1);
        check("bp_head_instr", instr, 32'h0000_0001);
        check("bp_head_pc", instr_pc, 32'h0);
        n0 = acc_instr.size();
        for (int c = 0; c < 20; c++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("bp_progress", 32'((acc_instr.size() - n0) >= 10), 32'd1);

        // Redirect while a request is outstanding (single and back-to-back).
        for (int variant = 0; variant < 2; variant++) begin
            fill_dir(32'h0100);
            dir_mem[0]  = 32'h1235_4441;
            dir_mem[64] = 32'h0505_4081;
            do_reset(1'b0);
            lat_min = 3;
            lat_max = 3;
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (variant == 1) cycle(1'b1, 1'b1, 1'b1, 32'h0000_2000);
            cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102);
            acc_instr.delete();
            acc_pc.delete();
            acc_len.delete();
            grant_q.delete();
            lat_min = 0;
            lat_max = 0;
            for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
            check("redir_accepts", 32'(acc_instr.size() >= 1), 32'd1);
            check("redir_grants", 32'(grant_q.size() >= 1), 32'd1);
            if (grant_q.size() >= 1) check("redir_fetch_addr", grant_q[0], 32'h0000_0100);
            if (acc_instr.size() >= 1) begin
                check("redir_first_pc", acc_pc[0], 32'h0000_0102);
                check("redir_first_instr", acc_instr[0], 32'h0000_0505);
                check("redir_first_len", 32'(acc_len[0]), 32'd2);
            end
        end

        // Grant withheld, then asynchronous reset in the middle of WAIT.
        fill_dir(32'h0);
        do_reset(1'b0);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("nognt_req", 32'(mem_req), 1);
        check("nognt_addr", mem_addr, 32'h0);
        lat_min = 5;
        lat_max = 5;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        lat_min = 0;
        lat_max = 0;
        for (int c = 0; c < 10; c++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("post_reset_first_valid", 32'(first_valid_cyc), 32'd2);
        check("post_reset_accepts", 32'(acc_pc.size() >= 1), 32'd1);
        if (acc_pc.size() >= 1) check("post_reset_first_pc", acc_pc[0], 32'h0);

        // Randomized run against the memory-image model.
        dir_mode = 1'b0;
        do_reset(1'b0);
        lat_min = 0;
        lat_max = 3;
        for (int c = 0; c < 4000; c++) begin
            r = $urandom;
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | (r & 32'hE);
            else rpc = r & 32'h0000_FFFE;
            cycle($urandom_range(99, 0) < 60, $urandom_range(99, 0) < 75,
                  $urandom_range(99, 0) < 3, rpc);
        end
        check("random_progress", 32'(acc_instr.size() > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the pipeline. It owns the fetch PC and issues word-aligned requests on the instruction memory port with a req/gnt/rvalid handshake. Returned words go into a 4-halfword alignment buffer, which turns them into 16-bit (RVC) and 32-bit instructions with their PCs. Handles redirects from branches and traps, including discarding in-flight responses, and downstream backpressure.

Parameters:
DataWidth, 32, width of PCs and addresses (from param_defs)
MemBusWidth, 32, instruction memory read data width; only 32 supported
ResetVector, 32'h0000_0000, PC after reset; bit 0 must be 0

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
mem_req  output  1  fetch request valid
mem_addr  output  DataWidth  word-aligned fetch address, bits [1:0] always 0
mem_gnt  input  1  request accepted this cycle (mem_req && mem_gnt)
mem_rvalid  input  1  read data valid; in order, one per granted request
mem_rdata  input  MemBusWidth  read data, little-endian halfwords
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  DataWidth  new PC; bit 0 ignored (treated as 0)
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  consumer accepts instr this cycle
instr  output  32  instruction; compressed ones are zero-extended in [31:16]
instr_pc  output  DataWidth  PC of instr
instr_len  output  3  PC increment: 2 (compressed) or 4

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: mem_req=0, mem_addr=ResetVector&~3, instr_valid=0, instr=0, instr_pc=ResetVector, instr_len=4, buffer empty, no outstanding request, discard=0, skip_lo=ResetVector[1].
- Reset while a request is outstanding: all state clears. A later rvalid for the lost request must not occur; the bench asserts this.
- States: RUN (request allowed) and WAIT (one request outstanding). At most one outstanding request.
- mem_req: asserted in RUN when buffer occupancy ≤ 2 halfwords and redirect=0.
- On grant: move to WAIT; fetch_addr += 4 (wraps modulo 2^DataWidth).
- WAIT→RUN: on mem_rvalid.
- mem_req with gnt=0: mem_addr stays stable and mem_req stays high until granted.
- Response handling: with discard=0, push mem_rdata[15:0] then [31:16]. If skip_lo=1, push only [31:16], then clear skip_lo.
- Response with discard=1: data dropped, discard cleared.
- Decode at buffer head (hw0):
  - hw0[1:0] != 2'b11 and count ≥ 1: compressed; instr={16'h0,hw0}, instr_len=2.
  - Otherwise, count ≥ 2: instr={hw1,hw0}, instr_len=4.
  - A 32-bit instruction with only one halfword buffered: instr_valid=0 until the next halfword arrives. This covers instructions crossing a word boundary.
- Outputs instr/instr_pc/instr_len/instr_valid are combinational from registered buffer state. Latency from rvalid to instr_valid is 1 cycle. Minimum from reset release to first instr_valid is 2 cycles (req+gnt in cycle 0, rvalid in cycle 1, valid in cycle 2).
- Pop: on instr_valid && instr_ready, pop 1 or 2 halfwords and instr_pc += instr_len. Push and pop in the same cycle are both applied; occupancy never exceeds 4.
- instr_valid=1 with instr_ready=0: instr/instr_pc held stable.
- Redirect has top priority over push, pop and request in the same cycle:
  - Buffer cleared; instr_valid=0 in the following cycle.
  - instr_pc=redirect_pc&~1; fetch_addr=redirect_pc&~3; skip_lo=redirect_pc[1].
  - If in WAIT and no rvalid this cycle: discard=1, stay in WAIT. Otherwise go to RUN.
  - mem_req=0 in the redirect cycle; requests resume the next cycle.
- Back-to-back redirects: the last one wins; discard remains set for the single outstanding response.
- mem_rvalid while not in WAIT: ignored (assertion).

Decomposition:
- param_defs gains:
  - fetch_state_e {FETCH_RUN, FETCH_WAIT}
  - localparam FetchBufHw=4
  - localparam ResetVector
  - function is_compressed(logic [1:0])
- Sub-module fetch_align_buf holds the halfword storage and occupancy.
  - Inputs: push_lo_en, push_hi_en, pop_cnt[1:0], flush.
  - Outputs: hw0, hw1, count[2:0].
- fetch_ctrl keeps the FSM, PCs, discard/skip flags and decode.

Test Plan:
- Reset, gnt=1, rvalid next cycle, memory word 0=32'h0000_0413 → mem_addr=0 at cycle 0; cycle 2: instr_valid=1, instr=32'h0000_0413, instr_pc=0, instr_len=4.
- Word 0=32'h4501_4081 (two RVC instructions), instr_ready=1 → instr=32'h0000_4081 at pc 0, then instr=32'h0000_4501 at pc 2; instr_len=2 for both.
- Word 0=32'h0413_4081 and word 4=32'hxxxx_0000 → RVC at pc 0, then cross-word instr 32'h0000_0413 at pc 2. instr_valid stays low until word 4 returns.
- instr_ready=0 for 10 cycles → mem_req drops once occupancy >2; instr/instr_pc unchanged; no data lost.
- redirect_pc=32'h0000_0102 while a request is outstanding → stale rvalid dropped; next mem_addr=32'h100; first instr_pc=32'h102 comes from the upper halfword.
- mem_gnt held 0 for 5 cycles → mem_req and mem_addr stable; rst_n pulsed mid-WAIT → all outputs return to reset values asynchronously.
